ex_seq_ctrl: RTL and testbench



---
 rtl/ex_ctrl_pkg.sv | 26 ++
 rtl/ex_flag_reg.sv | 45 ++++
 rtl/ex_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ex_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ex_ctrl_pkg
// Shared types and constants for the execute-stage sequencing controller.
//   ex_state_t        : controller FSM state encoding (IDLE / BUSY / HOLD)
//   FLAG_Z/V/N        : bit positions of the condition flags in every 3-bit
//                       flag vector (mask, ALU flags, architectural register)
//   DEFAULT_TIMEOUT   : default bound on BUSY cycles before force-completion
//   DEFAULT_CNT_W     : default busy-counter width (2**W must exceed timeout)
// ---------------------------------------------------------------------------
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } ex_state_t;

    localparam int unsigned FLAG_W = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    localparam int unsigned DEFAULT_TIMEOUT = 8;
    localparam int unsigned DEFAULT_CNT_W   = 4;

endpackage : ex_ctrl_pkg

// File: rtl/ex_flag_reg.sv
// ---------------------------------------------------------------------------
// ex_flag_reg
// Architectural condition-flag register with a per-bit write mask.
// A bit is loaded from d only when we is high and its mask bit is set;
// all other bits keep their value. Synchronous active-high reset to zero.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   we   : global write enable for this cycle
//   mask : per-bit write enables, [2]=Z [1]=V [0]=N
//   d    : new flag values
//   q    : registered flag values
// ---------------------------------------------------------------------------
module ex_flag_reg
    import ex_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [FLAG_W-1:0] mask,
    input  logic [FLAG_W-1:0] d,
    output logic [FLAG_W-1:0] q
);

    logic [FLAG_W-1:0] flag_reg;
    logic [FLAG_W-1:0] flag_next;

    // Per-bit select: new value only where the op is allowed to write.
    generate
        for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag_bit
            assign flag_next[gi] = (we && mask[gi]) ? d[gi] : flag_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg <= '0;
        end else begin
            flag_reg <= flag_next;
        end
    end

    assign q = flag_reg;

endmodule : ex_flag_reg

// File: rtl/ex_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ex_seq_ctrl
// Execute-stage sequencing controller. Accepts one decoded op at a time,
// launches the ALU with a single-cycle start pulse, waits for done (bounded
// by a timeout), commits the condition flags under the op's write mask, and
// holds the result valid until MEM accepts it.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   issue_valid       : decoded op present at ID/EX
//   issue_ready       : controller accepts an op this cycle (combinational)
//   issue_flag_mask   : flag write enables for the op, [2]=Z [1]=V [0]=N
//   alu_start         : one-cycle ALU launch pulse (registered)
//   alu_done          : ALU result and flags valid (only honoured in BUSY)
//   alu_flags         : ALU flag outputs, same bit order as the mask
//   ex_valid          : EX result valid toward MEM (registered)
//   mem_ready         : MEM accepts the EX result
//   stall             : hold IF/ID and ID/EX registers (combinational)
//   flush             : squash the in-flight op; wins over everything but rst
//   flags             : architectural flag register Z,V,N
//   timeout_err       : sticky, set when an op was force-completed
// ---------------------------------------------------------------------------
module ex_seq_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [FLAG_W-1:0] issue_flag_mask,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              ex_valid,
    input  logic              mem_ready,
    output logic              stall,
    input  logic              flush,
    output logic [FLAG_W-1:0] flags,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    ex_state_t         state_reg;
    ex_state_t         state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [FLAG_W-1:0] mask_reg;
    logic              alu_start_reg;
    logic              ex_valid_reg;
    logic              timeout_err_reg;

    logic              accept;
    logic              done_hit;
    logic              timeout_hit;
    logic              flag_we;

    // -----------------------------------------------------------------------
    // Handshake and completion decode
    // -----------------------------------------------------------------------
    always_comb begin
        issue_ready = 1'b0;
        if (!flush) begin
            issue_ready = (state_reg == ST_IDLE) ||
                          ((state_reg == ST_HOLD) && mem_ready);
        end
        accept      = issue_valid && issue_ready;
        stall       = issue_valid && !issue_ready;
        // Completion events only count in BUSY and are cancelled by flush.
        done_hit    = (state_reg == ST_BUSY) && !flush && alu_done;
        timeout_hit = (state_reg == ST_BUSY) && !flush && !alu_done &&
                      (cnt_reg == CNT_LIMIT);
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_hit || timeout_hit) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A new op accepted while MEM drains the old result goes
                    // straight back to BUSY, so there is no IDLE bubble.
                    if (mem_ready) begin
                        state_next = accept ? ST_BUSY : ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: output / datapath-control logic
    // -----------------------------------------------------------------------
    always_comb begin
        flag_we  = done_hit;
        cnt_next = cnt_reg;
        if (flush) begin
            cnt_next = '0;
        end else if (accept) begin
            // The start cycle is the first BUSY cycle, so counting starts at 1.
            cnt_next = CNT_W'(1);
        end else if ((state_reg == ST_BUSY) && !done_hit && !timeout_hit) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            mask_reg        <= '0;
            alu_start_reg   <= 1'b0;
            ex_valid_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            alu_start_reg <= accept;
            // ex_valid tracks residency in HOLD.
            ex_valid_reg  <= (state_next == ST_HOLD);
            if (accept) begin
                mask_reg <= issue_flag_mask;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    ex_flag_reg u_flag_reg (
        .clk  (clk),
        .rst  (rst),
        .we   (flag_we),
        .mask (mask_reg),
        .d    (alu_flags),
        .q    (flags)
    );

    assign alu_start   = alu_start_reg;
    assign ex_valid    = ex_valid_reg;
    assign timeout_err = timeout_err_reg;

endmodule : ex_seq_ctrl

// File: tb/tb_ex_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_seq_ctrl
// Directed bench for ex_seq_ctrl. Inputs change 1 time unit after a rising
// edge; outputs are sampled there as well, well away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_flag_mask;
    logic       alu_start;
    logic       alu_done;
    logic [2:0] alu_flags;
    logic       ex_valid;
    logic       mem_ready;
    logic       stall;
    logic       flush;
    logic [2:0] flags;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    ex_seq_ctrl #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_flag_mask (issue_flag_mask),
        .alu_start       (alu_start),
        .alu_done        (alu_done),
        .alu_flags       (alu_flags),
        .ex_valid        (ex_valid),
        .mem_ready       (mem_ready),
        .stall           (stall),
        .flush           (flush),
        .flags           (flags),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; return 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        issue_valid     = 1'b0;
        issue_flag_mask = 3'b000;
        alu_done        = 1'b0;
        alu_flags       = 3'b000;
        mem_ready       = 1'b0;
        flush           = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_flags",     32'(flags),       32'h0);
        check("rst_ex_valid",  32'(ex_valid),    32'h0);
        check("rst_alu_start", 32'(alu_start),   32'h0);
        check("rst_timeout",   32'(timeout_err), 32'h0);
        check("rst_ready",     32'(issue_ready), 32'h1);

        // ---------------- single op ----------------
        rst = 1'b0;
        issue_valid = 1'b1; issue_flag_mask = 3'b111; mem_ready = 1'b1;
        settle();
        check("t1_ready_idle", 32'(issue_ready), 32'h1);
        check("t1_stall_idle", 32'(stall),       32'h0);
        tick();                                       // t+1: BUSY
        issue_valid = 1'b0; alu_done = 1'b1; alu_flags = 3'b101;
        settle();
        check("t1_start",      32'(alu_start),   32'h1);
        check("t1_exv_busy",   32'(ex_valid),    32'h0);
        check("t1_ready_busy", 32'(issue_ready), 32'h0);
        tick();                                       // t+2: HOLD
        alu_done = 1'b0;
        check("t1_flags",      32'(flags),       32'h5);
        check("t1_exv",        32'(ex_valid),    32'h1);
        check("t1_start_off",  32'(alu_start),   32'h0);
        tick();                                       // t+3: IDLE
        check("t1_exv_idle",   32'(ex_valid),    32'h0);
        check("t1_ready_back", 32'(issue_ready), 32'h1);

        // ---------------- set all flags, then masked write back-to-back ----
        issue_valid = 1'b1; issue_flag_mask = 3'b111;
        tick();                                       // BUSY
        alu_done = 1'b1; alu_flags = 3'b111;
        issue_flag_mask = 3'b100;                     // next op, queued
        tick();                                       // HOLD, flags=111
        alu_done = 1'b0;
        check("t2_flags_all",  32'(flags),       32'h7);
        settle();
        check("t2_ready_hold", 32'(issue_ready), 32'h1);
        tick();                                       // accepted from HOLD
        check("t2_b2b_start",  32'(alu_start),   32'h1);
        check("t2_b2b_exv",    32'(ex_valid),    32'h0);
        alu_done = 1'b1; alu_flags = 3'b000;
        issue_flag_mask = 3'b010;
        mem_ready = 1'b0;
        tick();                                       // HOLD, masked commit
        alu_done = 1'b0;
        check("t2_masked",     32'(flags),       32'h3);

        // ---------------- backpressure ----------------
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("bp_stall_%0d", i), 32'(stall),       32'h1);
            check($sformatf("bp_exv_%0d",   i), 32'(ex_valid),    32'h1);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        check("bp_ready",      32'(issue_ready), 32'h1);
        check("bp_stall_rel",  32'(stall),       32'h0);
        tick();                                       // accept: t+1, BUSY
        issue_valid = 1'b0;
        check("bp_start",      32'(alu_start),   32'h1);

        // ---------------- timeout on this op ----------------
        for (int i = 2; i <= 8; i++) begin
            tick();                                   // t+2 .. t+8
            if (i == 2) check("to_start_once", 32'(alu_start), 32'h0);
        end
        check("to_exv_t8",     32'(ex_valid),    32'h0);
        check("to_err_t8",     32'(timeout_err), 32'h0);
        tick();                                       // t+9
        check("to_exv_t9",     32'(ex_valid),    32'h1);
        check("to_err_t9",     32'(timeout_err), 32'h1);
        check("to_flags",      32'(flags),       32'h3);
        tick();                                       // IDLE
        check("to_exv_idle",   32'(ex_valid),    32'h0);
        check("to_err_sticky", 32'(timeout_err), 32'h1);

        // ---------------- flush in BUSY with alu_done ----------------
        issue_valid = 1'b1; issue_flag_mask = 3'b111;
        tick();                                       // BUSY
        alu_done = 1'b1; alu_flags = 3'b111; flush = 1'b1;
        settle();
        check("fl_ready",      32'(issue_ready), 32'h0);
        check("fl_stall",      32'(stall),       32'h1);
        tick();                                       // IDLE
        check("fl_exv",        32'(ex_valid),    32'h0);
        check("fl_flags",      32'(flags),       32'h3);
        check("fl_start",      32'(alu_start),   32'h0);
        // Flush keeps the op from being taken in IDLE as well.
        alu_done = 1'b0;
        tick();
        check("fl_no_accept",  32'(alu_start),   32'h0);
        flush = 1'b0; issue_valid = 1'b0;
        settle();
        check("fl_ready_rel",  32'(issue_ready), 32'h1);

        // ---------------- alu_done ignored in IDLE ----------------
        alu_done = 1'b1; alu_flags = 3'b000;
        tick();
        alu_done = 1'b0;
        check("idle_done_flags", 32'(flags),     32'h3);
        check("idle_done_exv",   32'(ex_valid),  32'h0);

        // ---------------- reset in HOLD ----------------
        issue_valid = 1'b1; issue_flag_mask = 3'b111;
        tick();                                       // BUSY
        issue_valid = 1'b0; alu_done = 1'b1; alu_flags = 3'b101; mem_ready = 1'b0;
        tick();                                       // HOLD
        alu_done = 1'b0;
        check("rh_flags_pre",  32'(flags),       32'h5);
        check("rh_exv_pre",    32'(ex_valid),    32'h1);
        rst = 1'b1;
        tick();
        check("rh_flags",      32'(flags),       32'h0);
        check("rh_exv",        32'(ex_valid),    32'h0);
        check("rh_start",      32'(alu_start),   32'h0);
        check("rh_timeout",    32'(timeout_err), 32'h0);
        check("rh_ready",      32'(issue_ready), 32'h1);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_seq_ctrl
